// File: rtl/arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
package arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Source identifiers carried through a transaction
  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_D  = 1'b1;

  // Width of the memory latency countdown (latency 1..4 fits)
  localparam int LAT_W = 3;

  // Width of the consecutive-data-grant counter (limit 1..15 fits)
  localparam int RUN_W = 4;

endpackage

// File: rtl/arb_pick.sv
// Winner select between fetch and data requests, with a run counter that
// bounds how many data grants may pass a waiting fetch.
module arb_pick
  import arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_idle,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_grant,
  output logic o_src
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;

  // Pick a winner while idle: data first unless the fetch has waited out a full run
  always_comb begin
    o_grant = 1'b0;
    o_src   = SRC_IF;
    if (i_idle) begin
      if (i_d_req && i_if_req) begin
        o_grant = 1'b1;
        o_src   = (run_cnt_q == RUN_MAX) ? SRC_IF : SRC_D;
      end else if (i_d_req) begin
        o_grant = 1'b1;
        o_src   = SRC_D;
      end else if (i_if_req) begin
        o_grant = 1'b1;
        o_src   = SRC_IF;
      end
    end
  end

  // Count data grants that bypass a pending fetch; clear when fetch is served or absent
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (i_idle) begin
      if (!i_if_req || (o_grant && (o_src == SRC_IF))) begin
        run_cnt_d = '0;
      end else if (o_grant && (o_src == SRC_D) && (run_cnt_q != RUN_MAX)) begin
        run_cnt_d = run_cnt_q + 1'b1;
      end
    end
  end

  // Run counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch
// and load/store, one transaction at a time.
module unified_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ready,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ready,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              src_q, src_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic in_idle;
  logic pick_grant;
  logic pick_src;
  logic rdata_capture;

  assign in_idle       = (state_q == ST_IDLE);
  assign rdata_capture = (state_q == ST_WAIT) && (lat_cnt_q == '0);

  arb_pick #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_pick (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_idle   (in_idle),
    .i_if_req (i_if_req),
    .i_d_req  (i_d_req),
    .o_grant  (pick_grant),
    .o_src    (pick_src)
  );

  // State and datapath registers; reset discards any in-flight transaction
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      lat_cnt_q   <= '0;
      src_q       <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      src_q       <= src_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Next-state: stores return to idle straight after issue, reads wait out the latency
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_grant) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_WAIT;
          lat_cnt_d = LAT_W'(MEM_LAT - 1);
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: latch the winner's command so the memory strobe lands in ISSUE
  always_comb begin
    src_d       = src_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if (pick_grant) begin
      src_d    = pick_src;
      mem_en_d = 1'b1;
      if (pick_src == SRC_D) begin
        we_d        = i_d_we;
        mem_we_d    = i_d_we;
        mem_addr_d  = i_d_addr;
        mem_wdata_d = i_d_wdata;
      end else begin
        we_d       = 1'b0;
        mem_addr_d = i_if_addr;
      end
    end
    if (rdata_capture) begin
      if (src_q == SRC_IF) begin
        if_rdata_d = i_mem_rdata;
      end else begin
        d_rdata_d = i_mem_rdata;
      end
    end
  end

  // Outputs: handshakes are combinational from state and the current pick
  always_comb begin
    o_if_ready  = pick_grant && (pick_src == SRC_IF);
    o_d_ready   = pick_grant && (pick_src == SRC_D);
    o_if_rvalid = (state_q == ST_RESP) && (src_q == SRC_IF);
    o_d_rvalid  = (state_q == ST_RESP) && (src_q == SRC_D);
    o_busy      = (state_q != ST_IDLE);
  end

  assign o_if_rdata  = if_rdata_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: memory macro model plus a transaction-level
// reference that predicts handshakes, memory commands and responses per cycle.
module tb_unified_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int MAXR = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_if_req = 1'b0;
  logic [AW-1:0] i_if_addr = '0;
  logic          o_if_ready;
  logic          o_if_rvalid;
  logic [DW-1:0] o_if_rdata;
  logic          i_d_req = 1'b0;
  logic          i_d_we = 1'b0;
  logic [AW-1:0] i_d_addr = '0;
  logic [DW-1:0] i_d_wdata = '0;
  logic          o_d_ready;
  logic          o_d_rvalid;
  logic [DW-1:0] o_d_rdata;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  logic          o_busy;

  always #5 i_clk = ~i_clk;

  unified_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_DATA_RUN(MAXR)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_ready(o_if_ready),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_ready(o_d_ready), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  // ---------------- memory macro model (fixed latency, junk when not valid)
  logic [DW-1:0] mem      [64];
  logic [DW-1:0] pipe_dat [LAT];
  logic          pipe_vld [LAT];
  logic [DW-1:0] junk = '0;

  always @(posedge i_clk) begin
    junk <= $urandom;
    if (o_mem_en && o_mem_we) mem[o_mem_addr[5:0]] <= o_mem_wdata;
    pipe_vld[0] <= o_mem_en && !o_mem_we;
    pipe_dat[0] <= mem[o_mem_addr[5:0]];
    for (int k = 1; k < LAT; k++) begin
      pipe_vld[k] <= pipe_vld[k-1];
      pipe_dat[k] <= pipe_dat[k-1];
    end
  end

  assign i_mem_rdata = pipe_vld[LAT-1] ? pipe_dat[LAT-1] : junk;

  // ---------------- reference model state
  logic [DW-1:0] ref_mem [64];
  int            n_vec = 0;
  int            n_err = 0;
  int            n_txn = 0;
  int            cyc = 0;
  int            busy_left = 0;
  int            cmd_cyc = -1;
  int            rv_cyc = -1;
  int            run_m = 0;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rv_src = 1'b0;
  logic [DW-1:0] rv_data = '0;
  logic [DW-1:0] last_if = '0;
  logic [DW-1:0] last_d = '0;
  logic          model_on = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    busy_left = 0;
    cmd_cyc   = -1;
    rv_cyc    = -1;
    run_m     = 0;
    last_if   = '0;
    last_d    = '0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_if_ready", 64'(o_if_ready), 64'(0));
    chk("rst_d_ready", 64'(o_d_ready), 64'(0));
    chk("rst_if_rvalid", 64'(o_if_rvalid), 64'(0));
    chk("rst_d_rvalid", 64'(o_d_rvalid), 64'(0));
    chk("rst_if_rdata", 64'(o_if_rdata), 64'(0));
    chk("rst_d_rdata", 64'(o_d_rdata), 64'(0));
    chk("rst_mem_en", 64'(o_mem_en), 64'(0));
    chk("rst_mem_we", 64'(o_mem_we), 64'(0));
    chk("rst_mem_addr", 64'(o_mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(o_mem_wdata), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
  endtask

  // One model cycle: a transaction occupies the memory for a known number of
  // cycles after acceptance; everything is predicted from that timeline.
  task automatic model_step();
    logic exp_if_rv, exp_d_rv, g, gsrc;
    chk("busy", 64'(o_busy), 64'(busy_left != 0));
    chk("mem_en", 64'(o_mem_en), 64'(cyc == cmd_cyc));
    if (cyc == cmd_cyc) begin
      chk("mem_we", 64'(o_mem_we), 64'(cmd_we));
      chk("mem_addr", 64'(o_mem_addr), 64'(cmd_addr));
      if (cmd_we) chk("mem_wdata", 64'(o_mem_wdata), 64'(cmd_wdata));
    end
    exp_if_rv = (cyc == rv_cyc) && !rv_src;
    exp_d_rv  = (cyc == rv_cyc) && rv_src;
    if (exp_if_rv) last_if = rv_data;
    if (exp_d_rv)  last_d  = rv_data;
    chk("if_rvalid", 64'(o_if_rvalid), 64'(exp_if_rv));
    chk("d_rvalid", 64'(o_d_rvalid), 64'(exp_d_rv));
    chk("if_rdata", 64'(o_if_rdata), 64'(last_if));
    chk("d_rdata", 64'(o_d_rdata), 64'(last_d));

    g = 1'b0;
    gsrc = 1'b0;
    if (busy_left == 0) begin
      if (i_d_req && i_if_req) begin
        g = 1'b1;
        gsrc = (run_m >= MAXR) ? 1'b0 : 1'b1;
      end else if (i_d_req) begin
        g = 1'b1;
        gsrc = 1'b1;
      end else if (i_if_req) begin
        g = 1'b1;
        gsrc = 1'b0;
      end
      chk("if_ready", 64'(o_if_ready), 64'(g && !gsrc));
      chk("d_ready", 64'(o_d_ready), 64'(g && gsrc));
      if (!i_if_req || (g && !gsrc)) run_m = 0;
      else if (g && gsrc && run_m < MAXR) run_m = run_m + 1;
      if (g) begin
        n_txn++;
        cmd_cyc  = cyc + 1;
        cmd_we   = gsrc && i_d_we;
        cmd_addr = gsrc ? i_d_addr : i_if_addr;
        cmd_wdata = i_d_wdata;
        if (cmd_we) begin
          ref_mem[cmd_addr[5:0]] = cmd_wdata;
          busy_left = 1;
          $display("txn %0d @%0d: store addr=%h data=%h", n_txn, cyc, cmd_addr, cmd_wdata);
        end else begin
          busy_left = LAT + 2;
          rv_cyc  = cyc + 2 + LAT;
          rv_src  = gsrc;
          rv_data = ref_mem[cmd_addr[5:0]];
          $display("txn %0d @%0d: %s addr=%h expect=%h", n_txn, cyc,
                   gsrc ? "load " : "fetch", cmd_addr, rv_data);
        end
      end
    end else begin
      chk("if_ready_busy", 64'(o_if_ready), 64'(0));
      chk("d_ready_busy", 64'(o_d_ready), 64'(0));
      busy_left--;
    end
    cyc++;
  endtask

  always @(negedge i_clk) begin
    if (model_on && !i_rst) model_step();
  end

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom & 32'hF000_0000) | 32'($urandom_range(0, 63));
  endfunction

  // Random requesters obeying the hold-until-ready rule, with rare withdrawals
  task automatic run_random(input int ncyc, input int p_if, input int p_d,
                            input int p_store, input bit check_streak);
    logic took_if, took_d;
    int streak;
    streak = 0;
    repeat (ncyc) begin
      @(negedge i_clk);
      took_if = i_if_req && o_if_ready;
      took_d  = i_d_req && o_d_ready;
      if (check_streak) begin
        if (took_d && i_if_req) streak++;
        if (took_if) begin
          chk("starve_run", 64'(streak), 64'(MAXR));
          streak = 0;
        end
      end
      @(posedge i_clk);
      #1;
      if (took_if || !i_if_req) begin
        i_if_req  = ($urandom_range(0, 99) < p_if);
        i_if_addr = rand_addr();
      end else if (p_if < 100 && $urandom_range(0, 99) < 3) begin
        i_if_req = 1'b0;
      end
      if (took_d || !i_d_req) begin
        i_d_req   = ($urandom_range(0, 99) < p_d);
        i_d_we    = ($urandom_range(0, 99) < p_store);
        i_d_addr  = rand_addr();
        i_d_wdata = $urandom;
      end else if (p_d < 100 && $urandom_range(0, 99) < 3) begin
        i_d_req = 1'b0;
      end
    end
  endtask

  task automatic quiesce(input int n);
    @(posedge i_clk);
    #1;
    i_if_req = 1'b0;
    i_d_req  = 1'b0;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[0] = 32'hDEADBEEF;
    ref_mem[0] = 32'hDEADBEEF;
    for (int k = 0; k < LAT; k++) pipe_vld[k] = 1'b0;

    // reset state
    repeat (2) @(negedge i_clk);
    check_reset_outputs();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
    model_on = 1'b1;
    quiesce(2);

    // single fetch from 0x100 (word 0 holds DEADBEEF)
    i_if_req = 1'b1;
    i_if_addr = 32'h100;
    quiesce(LAT + 4);

    // store 0x12345678 to 0x20
    i_d_req = 1'b1;
    i_d_we = 1'b1;
    i_d_addr = 32'h20;
    i_d_wdata = 32'h12345678;
    quiesce(4);

    // load from 0x20 reads the stored value back
    i_d_req = 1'b1;
    i_d_we = 1'b0;
    i_d_addr = 32'h20;
    quiesce(LAT + 4);

    // reset while a load to 0x40 is waiting on memory
    i_d_req = 1'b1;
    i_d_we = 1'b0;
    i_d_addr = 32'h40;
    @(posedge i_clk);
    #1;
    i_d_req = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    model_reset();
    @(negedge i_clk);
    check_reset_outputs();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (LAT + 4) @(posedge i_clk);
    #1;

    // contention with fetch held high and loads back-to-back
    run_random(80, 100, 100, 0, 1'b1);
    quiesce(LAT + 4);

    // mixed random traffic
    run_random(3000, 55, 65, 40, 1'b0);
    quiesce(LAT + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
